// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared definitions for the UART receive device.
//   - rd register field positions
//   - command word bit positions
//   - receiver FSM state encoding
package uart_rx_pkg;

    // rd register layout
    localparam int DATA_LSB  = 0;
    localparam int VALID_BIT = 8;
    localparam int OVR_BIT   = 9;
    localparam int FERR_BIT  = 10;
    localparam int COUNT_LSB = 16;
    localparam int COUNT_W   = 5;

    // command word bits
    localparam int CMD_POP      = 0;
    localparam int CMD_CLR_OVR  = 1;
    localparam int CMD_CLR_FERR = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_rx_device_byte_fifo.sv
// byte_fifo: small byte FIFO with a separate occupancy counter.
//   clk, reset_n : clock, asynchronous active-low reset (pointers/count only)
//   push, din    : write request and byte; dropped when full unless a pop
//                  happens in the same cycle
//   pop          : read request; ignored when empty
//   head         : byte at the read pointer (undefined when empty)
//   count        : number of stored bytes, 0..DEPTH
//   empty, full  : occupancy status
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still succeeds then.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    // Storage carries data only; it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/uart_rx_device.sv
// uart_rx_device: memory-mapped 8N1 UART receiver with a byte FIFO.
//   clk, reset_n : system clock, asynchronous active-low reset
//   we, wd       : command write; wd[0] pop head, wd[1] clear overrun,
//                  wd[2] clear framing error
//   rd           : {11'b0, count[4:0], 5'b0, ferr, ovr, valid, head[7:0]}
//   rx           : asynchronous serial input, idle high
module uart_rx_device
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    input  logic        rx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_s1;
    logic             rx_s2;
    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_nxt;
    logic [7:0]       shreg;
    logic             shift_en;
    logic             byte_push;
    logic             ferr_set;
    logic             ovr_set;
    logic             ovr;
    logic             ferr;
    logic             pop_req;
    logic [7:0]       fifo_head;
    logic [FCW-1:0]   fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             unused_wd;

    assign unused_wd = ^wd[31:3];

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        bit_nxt   = bit_idx;
        shift_en  = 1'b0;
        byte_push = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rx_s2) state_nxt = START;
            end
            START: begin
                // Half a bit after the falling edge: re-check to reject glitches.
                if (cnt == HALF_LAST) begin
                    cnt_nxt = '0;
                    if (!rx_s2) begin
                        state_nxt = DATA;
                        bit_nxt   = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_nxt  = '0;
                    shift_en = 1'b1;
                    bit_nxt  = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cnt_nxt = '0;
                    if (rx_s2) begin
                        byte_push = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_set  = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // Hold off until a line break ends before hunting for a start bit.
                cnt_nxt = '0;
                if (rx_s2) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // LSB arrives first, so shift in from the top.
    always_ff @(posedge clk) begin
        if (shift_en) shreg <= {rx_s2, shreg[7:1]};
    end

    assign pop_req = we & wd[CMD_POP];

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (byte_push),
        .pop     (pop_req),
        .din     (shreg),
        .head    (fifo_head),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // A full FIFO is never empty, so a pop request always frees a slot here.
    assign ovr_set = byte_push & fifo_full & ~pop_req;

    // Sticky flags: a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            if (ovr_set)
                ovr <= 1'b1;
            else if (we && wd[CMD_CLR_OVR])
                ovr <= 1'b0;
            if (ferr_set)
                ferr <= 1'b1;
            else if (we && wd[CMD_CLR_FERR])
                ferr <= 1'b0;
        end
    end

    always_comb begin
        rd                        = '0;
        rd[DATA_LSB +: 8]         = fifo_empty ? 8'h00 : fifo_head;
        rd[VALID_BIT]             = ~fifo_empty;
        rd[OVR_BIT]               = ovr;
        rd[FERR_BIT]              = ferr;
        rd[COUNT_LSB +: COUNT_W]  = COUNT_W'(fifo_count);
    end

endmodule

// File: doc/uart_rx_device.md
# uart_rx_device

Memory-mapped serial input device for the tinymips I/O space. It samples an asynchronous 8N1 UART line and buffers received bytes in a small FIFO. It presents a single 32-bit status/data register on the same `we`/`wd`/`rd` bus as the other I/O devices. The CPU polls `rd` and pops bytes by writing a command word; the debug monitor uses it as its console receive path.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434: clock cycles per serial bit (50 MHz / 115200). Must be ≥ 4.
- `FIFO_DEPTH`, 4: number of byte entries. Must be a power of two, 2..16.

Ports:
- `clk`  input  1: system clock; all state on the rising edge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `we`  input  1: write strobe; a command is taken on any clock edge with `we`=1.
- `wd`  input  32: command word. Bit 0 pops the FIFO head, bit 1 clears the overrun flag, bit 2 clears the framing-error flag. Other bits are ignored.
- `rd`  output  32: status/data register, combinational from internal state.
- `rx`  input  1: serial line, asynchronous, idle high.

## Operation
- `rd` layout:
  - [7:0]: FIFO head byte, forced to 0 when the FIFO is empty.
  - [8]: valid, meaning the FIFO is non-empty.
  - [9]: overrun, sticky.
  - [10]: framing error, sticky.
  - [15:11]: 0.
  - [20:16]: entry count, 0..FIFO_DEPTH.
  - [31:21]: 0.
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1.
- Bit counter and sample counter are each sized by $clog2 of their range. Bits are received LSB first into a shift register.
- Receiver FSM:
  - IDLE: on synced `rx`=0, clear the sample counter and go to START.
  - START: after CLKS_PER_BIT/2 cycles, sample. If 0, go to DATA with bit index 0. If 1, treat it as a glitch and go to IDLE.
  - DATA: sample every CLKS_PER_BIT cycles. After the 8th bit, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample.
    - If 1, push the byte and go to IDLE.
    - If 0, set framing error, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until synced `rx`=1, then go to IDLE. This covers a line break.
- Push when full: the new byte is discarded, overrun is set, and FIFO contents are unchanged.
- Pop (`we` & `wd[0]`) when empty is ignored.
- Push and pop in the same cycle:
  - Non-empty: both occur and the count is unchanged.
  - Full: the pop frees the slot, so the push succeeds with no overrun.
  - Empty: the pushed byte is stored and the pop is ignored.
- Clearing a flag in the same cycle that it is set: the set wins.
- Pointers wrap modulo FIFO_DEPTH. The count is a separate register of width $clog2(FIFO_DEPTH)+1.

## Timing
- Reset: `rd`=32'h0, FSM in IDLE, FIFO empty, both flags 0. Reset mid-frame abandons the frame with no push and no flag set.
- Synchronizer latency is 2 cycles. The START sample lands mid-bit. Each data sample lands CLKS_PER_BIT cycles after the previous one.
- A pushed byte appears in `rd[7:0]`, with `rd[8]`=1, on the cycle after the STOP sample edge.
- A pop updates `rd` on the cycle after the write edge (`rd` is registered-state driven).
- A flag clear takes effect in `rd` on the cycle after the write.
- Back-to-back frames: a start bit immediately following the stop bit is accepted, since IDLE is re-entered right after the STOP sample.

## Structure
- Package `uart_rx_pkg` holds:
  - `rd` field bit positions (DATA_LSB, VALID_BIT, OVR_BIT, FERR_BIT, COUNT_LSB);
  - command bit positions (CMD_POP, CMD_CLR_OVR, CMD_CLR_FERR);
  - FSM state enum (IDLE, START, DATA, STOP, WAIT_HIGH).
- One sub-module, `byte_fifo`, parameterized by depth. It provides push/pop/data-in and head/count/empty/full, with simultaneous push/pop behavior as specified above.
- The FSM, synchronizer, flags and `rd` assembly live in the top level.

## Test plan
- Reset with `rx`=1 → `rd`=0. Send 8'hA5 with CLKS_PER_BIT=8 → `rd`=32'h0001_01A5 one cycle after the stop sample.
- 100-cycle frame with a 3-cycle low glitch on `rx` → no push, FSM back in IDLE, `rd`=0.
- FIFO_DEPTH=4: send 5 bytes 01..05 without popping → count 4, head 01, `rd[9]`=1.
  - Write wd=3 (pop + clear overrun) → head 02, count 3, overrun 0.
- Frame with stop bit 0 and `rx` held low for 50 cycles → no push, `rd[10]`=1. Send 8'h3C after `rx` returns high → accepted.
  - Write wd=4 → framing error clears.
- FIFO full, with a pop write issued on the exact cycle of the 5th byte's stop sample → count stays 4, no overrun, the last entry holds the new byte.
- Assert `reset_n`=0 during DATA with 2 bytes buffered → `rd`=0 immediately. After release, the next clean frame is received correctly.
